swt16_scoreboard: RTL and testbench
===================================

# swt16_scoreboard

Parametrised register scoreboard for the swt16 pipeline. It tracks in-flight register writes per architectural register, raises a combinational stall at decode on RAW and write-count-overflow hazards, and releases the stall at writeback. Squashed instructions cancel their pending writes through a configurable number of cancel ports. It sits beside the decoder: issue comes from DC, retire from WB, cancels from the EX flush logic.

## Interface
Parameters:
- REG_IDX_WIDTH, 4, register index width
- NUM_REGS, 16, tracked registers (≤ 2^REG_IDX_WIDTH)
- NUM_SRC, 3, source operand ports checked per issue
- NUM_CANCEL, 2, cancel ports (one per squashable stage)
- MAX_PENDING, 3, max outstanding writes per register
- CNT_WIDTH, 2, counter width, ≥ clog2(MAX_PENDING+1)

Ports:
- clock  in  1  single clock, rising edge
- reset  in  1  asynchronous, active-low reset
- in_issue_valid  in  1  DC presents an instruction
- in_issue_writes  in  1  instruction writes a register
- in_issue_dst_idx  in  REG_IDX_WIDTH  destination register
- in_src_used  in  NUM_SRC  per-source "operand read" flag
- in_src_idx  in  NUM_SRC*REG_IDX_WIDTH  packed source indices, port k at [k*W +: W]
- in_wb_valid  in  1  WB writes the register file this cycle
- in_wb_idx  in  REG_IDX_WIDTH  WB destination
- in_cancel_valid  in  NUM_CANCEL  squashed in-flight write, per port
- in_cancel_idx  in  NUM_CANCEL*REG_IDX_WIDTH  packed cancelled destinations
- out_stall  out  1  hold DC/IF; issue not accepted
- out_issue_accept  out  1  in_issue_valid & ~out_stall
- out_pending  out  NUM_REGS  bit r = count[r] != 0
- out_busy  out  1  any count nonzero
- out_error  out  1  sticky underflow/out-of-range flag

## Operation
- State: one CNT_WIDTH counter per register; one sticky error bit.
- Hazard (combinational): stall = in_issue_valid & (any k: in_src_used[k] & count[src_k] != 0, or in_issue_writes & count[dst] == MAX_PENDING).
- Registered counts only; no same-cycle WB bypass: a source whose WB occurs this cycle still stalls this cycle.
- Counter update per register r, per edge: next = count + inc − dec, where inc = accept & in_issue_writes & dst==r (0/1), dec = (in_wb_valid & wb_idx==r) + number of cancel ports with valid & idx==r. Multiple decrements to the same register sum.
- Issue+WB same register same cycle: net 0. Issue+WB+cancel: net −1.
- Underflow (dec > count + inc): count clamps to 0, out_error set.
- Any index ≥ NUM_REGS on a valid port: ignored for counting, out_error set.
- out_error clears only on reset.
- in_issue_valid low: out_stall 0, no increment.

## Timing
- Reset (asynchronous assertion, synchronous to clock on release): all counts 0, out_error 0; hence out_pending 0, out_busy 0, out_stall 0 for any inputs.
- Reset mid-operation discards all pending counts; the pipeline is flushed by the same reset.
- out_stall, out_issue_accept: combinational, same cycle as inputs.
- out_pending, out_busy, out_error: registered, one cycle after the causing edge.
- Write issued at edge t makes the register pending from cycle t+1. A consumer in cycle t+1 stalls.
- WB at cycle w clears the register (if count was 1) at edge w+1. A stalled consumer is accepted in cycle w+1.
- Counts never wrap: increment is blocked by the stall at MAX_PENDING, and decrement clamps at 0.

## Structure
- Shared package swt16_pkg: REG_IDX_WIDTH, NUM_REGS, and the clog2-based CNT_WIDTH derivation, as used by decoder, regfile, and top.
- Sub-module swt16_sb_counter: one saturating up/multi-down counter with an underflow flag, instantiated NUM_REGS times via generate. The top holds index decode, hazard OR-reduction, and the error register.

## Test plan
- Issue r3 write at t, then consumer reading r3 at t+1 → out_stall=1 until WB r3 at w. Accept in cycle w+1; out_pending[3] goes 1→0.
- Three issues to r5 with no WB (MAX_PENDING=3) → count 3, fourth issue stalls. One WB r5 → fourth accepted the next cycle, count stays 3.
- Same-cycle issue r2 write, WB r2, count 1 → count stays 1. Adding cancel r2 in the same cycle → count 0.
- Both cancel ports target r7 with count 2 → count 0, out_error=0. Repeat with count 1 → count 0, out_error=1 and sticky.
- Assert reset with r1 count 2 and a stalled consumer → counts 0, out_stall=0 immediately, out_busy=0.
- Source with in_src_used=0 on a pending register → no stall. Source index 15 with NUM_REGS=8 → ignored, out_error=1.

Source files
------------

// File: rtl/swt16_pkg.sv
// Shared swt16 pipeline constants and width helpers used by decoder, regfile and scoreboard.
package swt16_pkg;

  localparam int unsigned REG_IDX_WIDTH = 4;
  localparam int unsigned NUM_REGS      = 16;
  localparam int unsigned NUM_SRC       = 3;
  localparam int unsigned NUM_CANCEL    = 2;
  localparam int unsigned MAX_PENDING   = 3;

  // Bits needed to hold any value in 0..max_val.
  function automatic int unsigned sum_width(input int unsigned max_val);
    return (max_val < 1) ? 1 : $clog2(max_val + 1);
  endfunction

  localparam int unsigned CNT_WIDTH = sum_width(MAX_PENDING);

endpackage

// File: rtl/swt16_sb_counter.sv
// One per-register pending-write counter: single increment, multi-decrement,
// clamps at zero and flags the underflow combinationally.
module swt16_sb_counter #(
  parameter int unsigned CNT_WIDTH = 2,
  parameter int unsigned DEC_WIDTH = 2
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 i_inc,
  input  logic [DEC_WIDTH-1:0] i_dec,
  output logic [CNT_WIDTH-1:0] o_count,
  output logic                 o_underflow_c
);

  localparam int unsigned SUM_WIDTH = CNT_WIDTH + DEC_WIDTH + 1;

  logic [CNT_WIDTH-1:0] r_count;
  logic [SUM_WIDTH-1:0] w_up;
  logic [SUM_WIDTH-1:0] w_dec;
  logic [CNT_WIDTH-1:0] w_next;

  always_comb begin
    w_up          = SUM_WIDTH'(r_count) + SUM_WIDTH'(i_inc);
    w_dec         = SUM_WIDTH'(i_dec);
    o_underflow_c = (w_dec > w_up);
    w_next        = o_underflow_c ? '0 : CNT_WIDTH'(w_up - w_dec);
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) r_count <= '0;
    else        r_count <= w_next;
  end

  assign o_count = r_count;

endmodule

// File: rtl/swt16_scoreboard.sv
// Register scoreboard: counts in-flight writes per register, stalls decode on
// RAW / pending-overflow hazards, releases at writeback or cancel.
module swt16_scoreboard
  import swt16_pkg::*;
#(
  parameter int unsigned REG_IDX_WIDTH = swt16_pkg::REG_IDX_WIDTH,
  parameter int unsigned NUM_REGS      = swt16_pkg::NUM_REGS,
  parameter int unsigned NUM_SRC       = swt16_pkg::NUM_SRC,
  parameter int unsigned NUM_CANCEL    = swt16_pkg::NUM_CANCEL,
  parameter int unsigned MAX_PENDING   = swt16_pkg::MAX_PENDING,
  parameter int unsigned CNT_WIDTH     = swt16_pkg::CNT_WIDTH
) (
  input  logic                                clock,
  input  logic                                reset,
  input  logic                                in_issue_valid,
  input  logic                                in_issue_writes,
  input  logic [REG_IDX_WIDTH-1:0]            in_issue_dst_idx,
  input  logic [NUM_SRC-1:0]                  in_src_used,
  input  logic [NUM_SRC*REG_IDX_WIDTH-1:0]    in_src_idx,
  input  logic                                in_wb_valid,
  input  logic [REG_IDX_WIDTH-1:0]            in_wb_idx,
  input  logic [NUM_CANCEL-1:0]               in_cancel_valid,
  input  logic [NUM_CANCEL*REG_IDX_WIDTH-1:0] in_cancel_idx,
  output logic                                out_stall,
  output logic                                out_issue_accept,
  output logic [NUM_REGS-1:0]                 out_pending,
  output logic                                out_busy,
  output logic                                out_error
);

  // WB plus every cancel port may hit the same register in one cycle.
  localparam int unsigned DEC_WIDTH = sum_width(NUM_CANCEL + 1);

  logic [CNT_WIDTH-1:0] w_count [NUM_REGS];
  logic [DEC_WIDTH-1:0] w_dec   [NUM_REGS];
  logic [NUM_REGS-1:0]  w_inc;
  logic [NUM_REGS-1:0]  w_underflow;
  logic [NUM_REGS-1:0]  w_nz;
  logic [NUM_REGS-1:0]  w_full;
  logic                 w_raw;
  logic                 w_full_hit;
  logic                 w_stall;
  logic                 w_oor;
  logic                 r_error;

  // Hazard detection against registered counts only (no WB bypass).
  always_comb begin
    w_raw      = 1'b0;
    w_full_hit = 1'b0;
    for (int r = 0; r < NUM_REGS; r++) begin
      for (int k = 0; k < NUM_SRC; k++) begin
        if (in_src_used[k] && w_nz[r] &&
            (in_src_idx[k*REG_IDX_WIDTH +: REG_IDX_WIDTH] == REG_IDX_WIDTH'(r)))
          w_raw = 1'b1;
      end
      if (in_issue_writes && w_full[r] && (in_issue_dst_idx == REG_IDX_WIDTH'(r)))
        w_full_hit = 1'b1;
    end
    w_stall = in_issue_valid & (w_raw | w_full_hit);
  end

  assign out_stall        = w_stall;
  assign out_issue_accept = in_issue_valid & ~w_stall;

  // Per-register increment / summed decrement decode.
  always_comb begin
    for (int r = 0; r < NUM_REGS; r++) begin
      w_inc[r] = out_issue_accept & in_issue_writes & (in_issue_dst_idx == REG_IDX_WIDTH'(r));
      w_dec[r] = '0;
      if (in_wb_valid && (in_wb_idx == REG_IDX_WIDTH'(r)))
        w_dec[r] = w_dec[r] + DEC_WIDTH'(1);
      for (int c = 0; c < NUM_CANCEL; c++) begin
        if (in_cancel_valid[c] && (in_cancel_idx[c*REG_IDX_WIDTH +: REG_IDX_WIDTH] == REG_IDX_WIDTH'(r)))
          w_dec[r] = w_dec[r] + DEC_WIDTH'(1);
      end
    end
  end

  // Any valid port naming an untracked register is an error.
  always_comb begin
    w_oor = 1'b0;
    if (in_issue_valid && in_issue_writes && (32'(in_issue_dst_idx) >= NUM_REGS))
      w_oor = 1'b1;
    for (int k = 0; k < NUM_SRC; k++) begin
      if (in_issue_valid && in_src_used[k] &&
          (32'(in_src_idx[k*REG_IDX_WIDTH +: REG_IDX_WIDTH]) >= NUM_REGS))
        w_oor = 1'b1;
    end
    if (in_wb_valid && (32'(in_wb_idx) >= NUM_REGS))
      w_oor = 1'b1;
    for (int c = 0; c < NUM_CANCEL; c++) begin
      if (in_cancel_valid[c] && (32'(in_cancel_idx[c*REG_IDX_WIDTH +: REG_IDX_WIDTH]) >= NUM_REGS))
        w_oor = 1'b1;
    end
  end

  for (genvar g = 0; g < NUM_REGS; g++) begin : g_cnt
    swt16_sb_counter #(
      .CNT_WIDTH (CNT_WIDTH),
      .DEC_WIDTH (DEC_WIDTH)
    ) u_cnt (
      .clock         (clock),
      .reset         (reset),
      .i_inc         (w_inc[g]),
      .i_dec         (w_dec[g]),
      .o_count       (w_count[g]),
      .o_underflow_c (w_underflow[g])
    );
    assign w_nz[g]   = |w_count[g];
    assign w_full[g] = (w_count[g] == CNT_WIDTH'(MAX_PENDING));
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) r_error <= 1'b0;
    else        r_error <= r_error | w_oor | (|w_underflow);
  end

  assign out_pending = w_nz;
  assign out_busy    = |w_nz;
  assign out_error   = r_error;

endmodule

// File: tb/tb_swt16_scoreboard.sv
// Self-checking bench for swt16_scoreboard (NUM_REGS=12 so indices 12..15 are out of range).
module tb_swt16_scoreboard;

  localparam int unsigned W  = 4;
  localparam int unsigned NR = 12;
  localparam int unsigned NS = 3;
  localparam int unsigned NC = 2;
  localparam int unsigned MP = 3;

  logic            clock = 1'b0;
  logic            reset = 1'b1;
  logic            iv, iw, wbv;
  logic [W-1:0]    dst, wbi;
  logic [NS-1:0]   su;
  logic [NS*W-1:0] sidx;
  logic [NC-1:0]   cv;
  logic [NC*W-1:0] ci;
  logic            out_stall, out_issue_accept, out_busy, out_error;
  logic [NR-1:0]   out_pending;

  int unsigned mcnt [NR];
  bit          merr;
  int          checks = 0;
  int          errors = 0;

  swt16_scoreboard #(
    .REG_IDX_WIDTH (W), .NUM_REGS (NR), .NUM_SRC (NS),
    .NUM_CANCEL (NC), .MAX_PENDING (MP), .CNT_WIDTH (2)
  ) dut (
    .clock (clock), .reset (reset),
    .in_issue_valid (iv), .in_issue_writes (iw), .in_issue_dst_idx (dst),
    .in_src_used (su), .in_src_idx (sidx),
    .in_wb_valid (wbv), .in_wb_idx (wbi),
    .in_cancel_valid (cv), .in_cancel_idx (ci),
    .out_stall (out_stall), .out_issue_accept (out_issue_accept),
    .out_pending (out_pending), .out_busy (out_busy), .out_error (out_error)
  );

  always #5 clock = ~clock;

  // Reference model: hazard rule applied to the architectural pending counts.
  function automatic bit exp_stall();
    bit s = 1'b0;
    if (!iv) return 1'b0;
    for (int k = 0; k < NS; k++) begin
      int unsigned idx;
      idx = 32'(sidx[k*W +: W]);
      if (su[k] && idx < NR && mcnt[idx] != 0) s = 1'b1;
    end
    if (iw && 32'(dst) < NR && mcnt[32'(dst)] == MP) s = 1'b1;
    return s;
  endfunction

  function automatic logic [NR-1:0] exp_pending();
    logic [NR-1:0] e;
    for (int r = 0; r < NR; r++) e[r] = (mcnt[r] != 0);
    return e;
  endfunction

  // Apply this cycle's inputs to the model, then advance one clock.
  task automatic tick();
    bit acc;
    int unsigned inc, dec;
    acc = iv && !exp_stall();
    if (iv && iw && 32'(dst) >= NR) merr = 1'b1;
    for (int k = 0; k < NS; k++)
      if (iv && su[k] && 32'(sidx[k*W +: W]) >= NR) merr = 1'b1;
    if (wbv && 32'(wbi) >= NR) merr = 1'b1;
    for (int c = 0; c < NC; c++)
      if (cv[c] && 32'(ci[c*W +: W]) >= NR) merr = 1'b1;
    for (int r = 0; r < NR; r++) begin
      inc = (acc && iw && 32'(dst) == r) ? 1 : 0;
      dec = (wbv && 32'(wbi) == r) ? 1 : 0;
      for (int c = 0; c < NC; c++)
        if (cv[c] && 32'(ci[c*W +: W]) == r) dec++;
      if (dec > mcnt[r] + inc) begin
        mcnt[r] = 0;
        merr    = 1'b1;
      end else begin
        mcnt[r] = mcnt[r] + inc - dec;
      end
    end
    @(posedge clock);
    #1;
  endtask

  task automatic idle();
    iv = 0; iw = 0; dst = '0; su = '0; sidx = '0;
    wbv = 0; wbi = '0; cv = '0; ci = '0;
  endtask

  task automatic model_clear();
    for (int r = 0; r < NR; r++) mcnt[r] = 0;
    merr = 1'b0;
  endtask

  task automatic do_reset();
    idle();
    reset = 1'b0;
    model_clear();
    @(posedge clock);
    @(negedge clock);
    reset = 1'b1;
    @(posedge clock);
    #1;
  endtask

  task automatic issue(input logic [W-1:0] r);
    idle(); iv = 1; iw = 1; dst = r;
    tick();
    idle();
  endtask

  task automatic test_reset();
    idle();
    #2 reset = 1'b0;
    iv = 1; iw = 1; dst = 4'($urandom); su = '1; sidx = 12'($urandom);
    wbv = 1; wbi = 4'($urandom);
    #1;
    checks++; if (out_stall !== 1'b0) begin errors++; $display("FAIL reset_stall got %0b exp 0", out_stall); end
    checks++; if (out_pending !== '0) begin errors++; $display("FAIL reset_pending got %0h exp 0", out_pending); end
    checks++; if (out_busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %0b exp 0", out_busy); end
    checks++; if (out_error !== 1'b0) begin errors++; $display("FAIL reset_error got %0b exp 0", out_error); end
    do_reset();
  endtask

  task automatic test_raw();
    idle(); iv = 1; iw = 1; dst = 3; #1;
    checks++; if (out_issue_accept !== 1'b1) begin errors++; $display("FAIL raw_issue_acc got %0b exp 1", out_issue_accept); end
    tick(); idle();
    checks++; if (out_pending[3] !== 1'b1) begin errors++; $display("FAIL raw_pend_set got %0b exp 1", out_pending[3]); end
    iv = 1; su = 3'b001; sidx[3:0] = 4'd3; #1;
    checks++; if (out_stall !== 1'b1) begin errors++; $display("FAIL raw_stall got %0b exp 1", out_stall); end
    tick(); tick(); #1;
    checks++; if (out_stall !== 1'b1) begin errors++; $display("FAIL raw_stall_hold got %0b exp 1", out_stall); end
    wbv = 1; wbi = 3; #1;
    checks++; if (out_stall !== 1'b1) begin errors++; $display("FAIL raw_no_bypass got %0b exp 1", out_stall); end
    tick(); wbv = 0; #1;
    checks++; if (out_issue_accept !== 1'b1) begin errors++; $display("FAIL raw_release got %0b exp 1", out_issue_accept); end
    checks++; if (out_pending[3] !== 1'b0) begin errors++; $display("FAIL raw_pend_clr got %0b exp 0", out_pending[3]); end
    tick(); idle();
  endtask

  task automatic test_max_pending();
    idle(); iv = 1; iw = 1; dst = 5;
    for (int i = 0; i < 3; i++) begin
      #1;
      checks++; if (out_issue_accept !== 1'b1) begin errors++; $display("FAIL maxp_acc%0d got %0b exp 1", i, out_issue_accept); end
      tick();
    end
    checks++; if (out_stall !== 1'b1) begin errors++; $display("FAIL maxp_full got %0b exp 1", out_stall); end
    wbv = 1; wbi = 5; #1;
    checks++; if (out_stall !== 1'b1) begin errors++; $display("FAIL maxp_wb_same got %0b exp 1", out_stall); end
    tick(); wbv = 0; #1;
    checks++; if (out_issue_accept !== 1'b1) begin errors++; $display("FAIL maxp_after_wb got %0b exp 1", out_issue_accept); end
    tick(); #1;
    checks++; if (out_stall !== 1'b1) begin errors++; $display("FAIL maxp_refull got %0b exp 1", out_stall); end
    idle(); wbv = 1; wbi = 5;
    tick(); tick();
    checks++; if (out_pending[5] !== 1'b1) begin errors++; $display("FAIL maxp_drain2 got %0b exp 1", out_pending[5]); end
    tick(); idle();
    checks++; if (out_pending[5] !== 1'b0) begin errors++; $display("FAIL maxp_drain3 got %0b exp 0", out_pending[5]); end
  endtask

  task automatic test_same_cycle();
    issue(2);
    iv = 1; iw = 1; dst = 2; wbv = 1; wbi = 2; #1;
    checks++; if (out_issue_accept !== 1'b1) begin errors++; $display("FAIL same_acc got %0b exp 1", out_issue_accept); end
    tick();
    checks++; if (out_pending[2] !== 1'b1) begin errors++; $display("FAIL same_net0 got %0b exp 1", out_pending[2]); end
    cv = 2'b01; ci[3:0] = 4'd2;
    tick(); idle();
    checks++; if (out_pending[2] !== 1'b0) begin errors++; $display("FAIL same_cancel got %0b exp 0", out_pending[2]); end
    checks++; if (out_error !== 1'b0) begin errors++; $display("FAIL same_err got %0b exp 0", out_error); end
  endtask

  task automatic test_cancel();
    issue(7); issue(7);
    cv = 2'b11; ci = {4'd7, 4'd7};
    tick(); idle();
    checks++; if (out_pending[7] !== 1'b0) begin errors++; $display("FAIL cancel2_pend got %0b exp 0", out_pending[7]); end
    checks++; if (out_error !== 1'b0) begin errors++; $display("FAIL cancel2_err got %0b exp 0", out_error); end
    issue(7);
    cv = 2'b11; ci = {4'd7, 4'd7};
    tick(); idle();
    checks++; if (out_pending[7] !== 1'b0) begin errors++; $display("FAIL cancel_uf_pend got %0b exp 0", out_pending[7]); end
    checks++; if (out_error !== 1'b1) begin errors++; $display("FAIL cancel_uf_err got %0b exp 1", out_error); end
    tick(); tick();
    checks++; if (out_error !== 1'b1) begin errors++; $display("FAIL cancel_sticky got %0b exp 1", out_error); end
  endtask

  task automatic test_reset_mid();
    issue(1); issue(1);
    iv = 1; su = 3'b001; sidx[3:0] = 4'd1; #1;
    checks++; if (out_stall !== 1'b1) begin errors++; $display("FAIL rmid_pre got %0b exp 1", out_stall); end
    reset = 1'b0; #1;
    checks++; if (out_stall !== 1'b0) begin errors++; $display("FAIL rmid_stall got %0b exp 0", out_stall); end
    checks++; if (out_busy !== 1'b0) begin errors++; $display("FAIL rmid_busy got %0b exp 0", out_busy); end
    checks++; if (out_error !== 1'b0) begin errors++; $display("FAIL rmid_err got %0b exp 0", out_error); end
    do_reset();
  endtask

  task automatic test_src_filter();
    issue(4);
    iv = 1; su = 3'b000; sidx = {4'd4, 4'd4, 4'd4}; #1;
    checks++; if (out_stall !== 1'b0) begin errors++; $display("FAIL unused_src got %0b exp 0", out_stall); end
    tick();
    su = 3'b010; sidx = {4'd0, 4'd15, 4'd0}; #1;
    checks++; if (out_stall !== 1'b0) begin errors++; $display("FAIL oor_stall got %0b exp 0", out_stall); end
    tick(); idle();
    checks++; if (out_error !== 1'b1) begin errors++; $display("FAIL oor_err got %0b exp 1", out_error); end
    checks++; if (out_pending !== exp_pending()) begin errors++; $display("FAIL oor_pend got %0h exp %0h", out_pending, exp_pending()); end
    do_reset();
  endtask

  function automatic logic [W-1:0] pick_idx(input bit allow_oor);
    if (allow_oor && $urandom_range(0, 15) == 0) return 4'd15;
    return W'($urandom_range(0, NR - 1));
  endfunction

  // Prefer registers that actually have writes in flight so counts drain.
  function automatic logic [W-1:0] pick_busy(input bit allow_oor);
    int unsigned q[$];
    for (int r = 0; r < NR; r++) if (mcnt[r] != 0) q.push_back(r);
    if (q.size() == 0 || allow_oor) return pick_idx(allow_oor);
    return W'(q[$urandom_range(0, q.size() - 1)]);
  endfunction

  task automatic test_random(input bit wild, input int n);
    bit es;
    for (int i = 0; i < n; i++) begin
      iv  = 1'($urandom_range(0, 1));
      iw  = 1'($urandom_range(0, 3) != 0);
      dst = pick_idx(wild);
      su  = 3'($urandom);
      for (int k = 0; k < NS; k++) sidx[k*W +: W] = pick_idx(wild);
      wbv = 1'($urandom_range(0, 2) == 0);
      wbi = pick_busy(wild);
      for (int c = 0; c < NC; c++) begin
        cv[c] = ($urandom_range(0, 7) == 0);
        ci[c*W +: W] = pick_busy(wild);
      end
      #1;
      es = exp_stall();
      checks++; if (out_stall !== es) begin errors++; $display("FAIL rnd_stall cyc %0d got %0b exp %0b", i, out_stall, es); end
      checks++; if (out_issue_accept !== (iv && !es)) begin errors++; $display("FAIL rnd_accept cyc %0d got %0b exp %0b", i, out_issue_accept, iv && !es); end
      tick();
      checks++; if (out_pending !== exp_pending()) begin errors++; $display("FAIL rnd_pending cyc %0d got %0h exp %0h", i, out_pending, exp_pending()); end
      checks++; if (out_busy !== (|exp_pending())) begin errors++; $display("FAIL rnd_busy cyc %0d got %0b exp %0b", i, out_busy, |exp_pending()); end
      checks++; if (out_error !== merr) begin errors++; $display("FAIL rnd_error cyc %0d got %0b exp %0b", i, out_error, merr); end
    end
    idle();
  endtask

  initial begin
    idle();
    model_clear();
    test_reset();
    test_raw();
    test_max_pending();
    test_same_cycle();
    test_cancel();
    test_reset_mid();
    test_src_filter();
    test_random(1'b0, 300);
    do_reset();
    test_random(1'b1, 300);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
